speicher_arbiter: RTL and testbench
===================================

Name: speicher_arbiter

Overview:
- Shares one single-port memory between the CPU instruction-fetch port and the CPU data port.
- Sits between the CPU and the memory; it replaces the two separate memory connections.
- Serialises the accesses, latches address and write data at grant, and returns one-cycle completion pulses matching the CPU handshake signals (InstruktionGeladen, DatenGeladen, DatenGespeichert).

Parameters:
- ADRESS_BREITE, 32, width of all address buses.
- DATEN_BREITE, 32, width of all data buses.
- ZEITLIMIT, 255, strobe cycles without SpeicherFertig before an access is aborted (used only with ZEITLIMIT_EN).

Ports:
- Clock  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- InstruktionAdresse  in  ADRESS_BREITE  fetch address.
- LeseInstruktion  in  1  fetch request (level).
- Instruktion  out  DATEN_BREITE  fetched word (registered).
- InstruktionGeladen  out  1  fetch completion pulse.
- DatenAdresse  in  ADRESS_BREITE  load/store address.
- DatenRaus  in  DATEN_BREITE  store data from CPU.
- LeseDaten  in  1  load request (level).
- SchreibeDaten  in  1  store request (level).
- DatenRein  out  DATEN_BREITE  loaded word (registered).
- DatenGeladen  out  1  load completion pulse.
- DatenGespeichert  out  1  store completion pulse.
- SpeicherAdresse  out  ADRESS_BREITE  memory address (registered).
- SpeicherSchreibDaten  out  DATEN_BREITE  memory write data (registered).
- SpeicherLesen  out  1  memory read strobe.
- SpeicherSchreiben  out  1  memory write strobe.
- SpeicherLeseDaten  in  DATEN_BREITE  memory read data, valid when SpeicherFertig is high.
- SpeicherFertig  in  1  memory access done.
- Fehler  out  1  sticky timeout flag (see Optional Feature).

Behaviour:
- Reset values: all outputs 0, state LEERLAUF, LetzterWarDaten=0.
- States:
  - LEERLAUF: idle, waiting for a request.
  - INSTR: fetch in progress.
  - LESEN: load in progress.
  - SCHREIBEN: store in progress.
  - FERTIG: one-cycle completion state.
- LEERLAUF, grant at the rising edge:
  - Data request over fetch, except when LetzterWarDaten=1 and LeseInstruktion=1: the fetch wins (alternation, no starvation).
  - SchreibeDaten together with LeseDaten: treated as a store.
  - On grant: latch SpeicherAdresse (plus SpeicherSchreibDaten for a store), assert the matching strobe from the next cycle, update LetzterWarDaten.
- INSTR / LESEN / SCHREIBEN:
  - The strobe is held high until SpeicherFertig is sampled high.
  - SpeicherFertig in the first strobe cycle is legal.
  - On that edge: strobe drops, read data is latched into Instruktion or DatenRein, next state FERTIG.
- FERTIG:
  - Exactly one of InstruktionGeladen, DatenGeladen or DatenGespeichert is high for this one cycle, then LEERLAUF.
  - The requester must drop its request on the edge that samples the pulse. A request still high in LEERLAUF afterwards is a new access.
- Latency:
  - The request is sampled at edge k; the strobe is high from cycle k+1.
  - SpeicherFertig is sampled at edge m; the pulse is high in cycle m+1.
  - Minimum request-to-pulse latency is 2 cycles; back-to-back throughput is 1 access per 3 cycles.
- Instruktion and DatenRein hold their value until the next completion of the same kind. A store never changes DatenRein.
- Strobes are mutually exclusive; at most one is high in any cycle.
- Requests dropped during an access are ignored; the access completes and still pulses.
- SpeicherFertig while no strobe is active is ignored.
- Reset mid-access: same edge to LEERLAUF, strobes low, no completion pulse, latched data cleared.

Optional Feature:
- Macro ZEITLIMIT_EN.
- With it:
  - A counter runs while a strobe is high.
  - After ZEITLIMIT strobe cycles without SpeicherFertig: strobe drops, state FERTIG, normal completion pulse, read data latched as 0.
  - Fehler is set and stays 1 until Reset.
- Without it: accesses wait indefinitely, no counter is built, Fehler is tied to 0.

Test Plan:
- Fetch, addr 0x10, memory returns 0xDEADBEEF with SpeicherFertig in the first strobe cycle -> SpeicherLesen for 1 cycle, InstruktionGeladen 1 cycle later, Instruktion=0xDEADBEEF, latency 2.
- Store, addr 0x20, data 0x12345678, SpeicherFertig after 3 strobe cycles -> SpeicherSchreiben high 3 cycles with the latched address/data, DatenGespeichert one pulse, DatenRein unchanged.
- LeseDaten and LeseInstruktion both high in LEERLAUF -> load served first, then fetch; with both re-asserted after the fetch -> load again (alternation).
- Reset asserted in the 2nd strobe cycle of a load -> next cycle all outputs 0, no DatenGeladen; the next request is served normally.
- Under ZEITLIMIT_EN with ZEITLIMIT=4 and SpeicherFertig held low -> strobe high for exactly 4 cycles, DatenGeladen pulse, DatenRein=0, Fehler=1 until Reset.
- SchreibeDaten and LeseDaten both high -> only SpeicherSchreiben, DatenGespeichert pulse, no DatenGeladen.

Source files
------------

// File: rtl/speicher_arbiter_if.sv
// speicher_arbiter_if: CPU-side and memory-side signals of the shared memory arbiter.
// slave  = arbiter view, master = CPU/memory environment view.
interface speicher_arbiter_if #(
  parameter int unsigned ADRESS_BREITE = 32,
  parameter int unsigned DATEN_BREITE  = 32
);
  // CPU fetch port
  logic [ADRESS_BREITE-1:0] InstruktionAdresse;
  logic                     LeseInstruktion;
  logic [DATEN_BREITE-1:0]  Instruktion;
  logic                     InstruktionGeladen;
  // CPU data port
  logic [ADRESS_BREITE-1:0] DatenAdresse;
  logic [DATEN_BREITE-1:0]  DatenRaus;
  logic                     LeseDaten;
  logic                     SchreibeDaten;
  logic [DATEN_BREITE-1:0]  DatenRein;
  logic                     DatenGeladen;
  logic                     DatenGespeichert;
  // single-port memory
  logic [ADRESS_BREITE-1:0] SpeicherAdresse;
  logic [DATEN_BREITE-1:0]  SpeicherSchreibDaten;
  logic                     SpeicherLesen;
  logic                     SpeicherSchreiben;
  logic [DATEN_BREITE-1:0]  SpeicherLeseDaten;
  logic                     SpeicherFertig;
  // status
  logic                     Fehler;

  modport slave (
    input  InstruktionAdresse, LeseInstruktion,
    output Instruktion, InstruktionGeladen,
    input  DatenAdresse, DatenRaus, LeseDaten, SchreibeDaten,
    output DatenRein, DatenGeladen, DatenGespeichert,
    output SpeicherAdresse, SpeicherSchreibDaten, SpeicherLesen, SpeicherSchreiben,
    input  SpeicherLeseDaten, SpeicherFertig,
    output Fehler
  );

  modport master (
    output InstruktionAdresse, LeseInstruktion,
    input  Instruktion, InstruktionGeladen,
    output DatenAdresse, DatenRaus, LeseDaten, SchreibeDaten,
    input  DatenRein, DatenGeladen, DatenGespeichert,
    input  SpeicherAdresse, SpeicherSchreibDaten, SpeicherLesen, SpeicherSchreiben,
    output SpeicherLeseDaten, SpeicherFertig,
    input  Fehler
  );
endinterface

// File: rtl/speicher_arbiter.sv
// speicher_arbiter: shares one single-port memory between the CPU fetch and data ports.
// Optional build macro ZEITLIMIT_EN: aborts a strobe after ZEITLIMIT cycles without
// SpeicherFertig and raises the sticky Fehler flag.
module speicher_arbiter #(
  parameter int unsigned ADRESS_BREITE = 32,
  parameter int unsigned DATEN_BREITE  = 32,
  parameter int unsigned ZEITLIMIT     = 255
) (
  input  logic              Clock,
  input  logic              Reset,
  speicher_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    LEERLAUF  = 3'd0,
    INSTR     = 3'd1,
    LESEN     = 3'd2,
    SCHREIBEN = 3'd3,
    FERTIG    = 3'd4
  } zustand_t;

  zustand_t                 r_state;
  zustand_t                 w_next;

  logic [ADRESS_BREITE-1:0] r_adresse;
  logic [DATEN_BREITE-1:0]  r_schreib_daten;
  logic                     r_lesen;
  logic                     r_schreiben;
  logic [DATEN_BREITE-1:0]  r_instruktion;
  logic [DATEN_BREITE-1:0]  r_daten_rein;
  logic                     r_instr_geladen;
  logic                     r_daten_geladen;
  logic                     r_daten_gespeichert;
  logic                     r_letzter_war_daten;

  logic                     w_daten_anf;
  logic                     w_grant_instr;
  logic                     w_grant_lesen;
  logic                     w_grant_schreiben;
  logic                     w_abschluss;
  logic                     w_timeout;
  logic                     w_strobe;
  logic [DATEN_BREITE-1:0]  w_lese_daten;

  assign w_daten_anf  = bus.LeseDaten | bus.SchreibeDaten;
  assign w_strobe     = r_lesen | r_schreiben;
  // An aborted access delivers zero instead of whatever is on the memory bus
  assign w_lese_daten = w_timeout ? '0 : bus.SpeicherLeseDaten;

`ifdef ZEITLIMIT_EN
  localparam int unsigned ZAEHLER_BREITE = $clog2(ZEITLIMIT + 1);

  logic [ZAEHLER_BREITE-1:0] r_zaehler;
  logic                      r_fehler;

  assign w_timeout = w_strobe && !bus.SpeicherFertig &&
                     (r_zaehler == ZAEHLER_BREITE'(ZEITLIMIT - 1));

  // Strobe cycle counter and sticky timeout flag
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_zaehler <= '0;
      r_fehler  <= 1'b0;
    end else begin
      if (w_strobe && !w_abschluss) r_zaehler <= r_zaehler + ZAEHLER_BREITE'(1);
      else                          r_zaehler <= '0;
      if (w_timeout)                r_fehler  <= 1'b1;
    end
  end

  assign bus.Fehler = r_fehler;
`else
  logic w_unused_zeitlimit;

  // The limit has no effect without the timeout logic
  assign w_unused_zeitlimit = ^ZEITLIMIT;
  assign w_timeout          = 1'b0;
  assign bus.Fehler         = 1'b0;
`endif

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) r_state <= LEERLAUF;
    else       r_state <= w_next;
  end

  // Next state, grant selection and completion detection
  always_comb begin
    w_next            = r_state;
    w_grant_instr     = 1'b0;
    w_grant_lesen     = 1'b0;
    w_grant_schreiben = 1'b0;
    w_abschluss       = 1'b0;
    unique case (r_state)
      LEERLAUF: begin
        // Data port has priority unless it was served last and a fetch is waiting
        if (w_daten_anf && !(r_letzter_war_daten && bus.LeseInstruktion)) begin
          if (bus.SchreibeDaten) begin
            w_grant_schreiben = 1'b1;
            w_next            = SCHREIBEN;
          end else begin
            w_grant_lesen = 1'b1;
            w_next        = LESEN;
          end
        end else if (bus.LeseInstruktion) begin
          w_grant_instr = 1'b1;
          w_next        = INSTR;
        end
      end
      INSTR, LESEN, SCHREIBEN: begin
        if (bus.SpeicherFertig || w_timeout) begin
          w_abschluss = 1'b1;
          w_next      = FERTIG;
        end
      end
      FERTIG:  w_next = LEERLAUF;
      default: w_next = LEERLAUF;
    endcase
  end

  // Address/data latching, strobes, read data capture and completion pulses
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_adresse           <= '0;
      r_schreib_daten     <= '0;
      r_lesen             <= 1'b0;
      r_schreiben         <= 1'b0;
      r_instruktion       <= '0;
      r_daten_rein        <= '0;
      r_instr_geladen     <= 1'b0;
      r_daten_geladen     <= 1'b0;
      r_daten_gespeichert <= 1'b0;
      r_letzter_war_daten <= 1'b0;
    end else begin
      r_instr_geladen     <= 1'b0;
      r_daten_geladen     <= 1'b0;
      r_daten_gespeichert <= 1'b0;

      if (w_grant_instr) begin
        r_adresse           <= bus.InstruktionAdresse;
        r_lesen             <= 1'b1;
        r_letzter_war_daten <= 1'b0;
      end
      if (w_grant_lesen) begin
        r_adresse           <= bus.DatenAdresse;
        r_lesen             <= 1'b1;
        r_letzter_war_daten <= 1'b1;
      end
      if (w_grant_schreiben) begin
        r_adresse           <= bus.DatenAdresse;
        r_schreib_daten     <= bus.DatenRaus;
        r_schreiben         <= 1'b1;
        r_letzter_war_daten <= 1'b1;
      end

      if (w_abschluss) begin
        r_lesen     <= 1'b0;
        r_schreiben <= 1'b0;
        case (r_state)
          INSTR: begin
            r_instruktion   <= w_lese_daten;
            r_instr_geladen <= 1'b1;
          end
          LESEN: begin
            r_daten_rein    <= w_lese_daten;
            r_daten_geladen <= 1'b1;
          end
          SCHREIBEN: r_daten_gespeichert <= 1'b1;
          default:   ;
        endcase
      end
    end
  end

  assign bus.SpeicherAdresse      = r_adresse;
  assign bus.SpeicherSchreibDaten = r_schreib_daten;
  assign bus.SpeicherLesen        = r_lesen;
  assign bus.SpeicherSchreiben    = r_schreiben;
  assign bus.Instruktion          = r_instruktion;
  assign bus.InstruktionGeladen   = r_instr_geladen;
  assign bus.DatenRein            = r_daten_rein;
  assign bus.DatenGeladen         = r_daten_geladen;
  assign bus.DatenGespeichert     = r_daten_gespeichert;

endmodule

// File: tb/tb_speicher_arbiter.sv
// tb_speicher_arbiter: directed vectors with hand-computed expectations for speicher_arbiter.
module tb_speicher_arbiter;

  logic Clock;
  logic Reset;
  int   n_checks;
  int   n_errors;

  speicher_arbiter_if #(.ADRESS_BREITE(32), .DATEN_BREITE(32)) bus ();

  speicher_arbiter #(
    .ADRESS_BREITE(32),
    .DATEN_BREITE (32),
    .ZEITLIMIT    (4)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  // 100 MHz clock
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] ist, input logic [31:0] soll);
    n_checks++;
    if (ist !== soll) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, ist, soll);
    end
  endtask

  // Advance one cycle; outputs are then read 1 ns after the edge
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_strobes(input string tag, input logic lesen, input logic schreiben);
    check({tag, "_lesen"},     32'(bus.SpeicherLesen),     32'(lesen));
    check({tag, "_schreiben"}, 32'(bus.SpeicherSchreiben), 32'(schreiben));
  endtask

  // Pulses packed as {InstruktionGeladen, DatenGeladen, DatenGespeichert}
  task automatic check_pulses(input string tag, input logic [2:0] soll);
    check(tag, 32'({bus.InstruktionGeladen, bus.DatenGeladen, bus.DatenGespeichert}), 32'(soll));
  endtask

  initial begin
    n_checks                 = 0;
    n_errors                 = 0;
    Clock                    = 1'b0;
    Reset                    = 1'b1;
    bus.InstruktionAdresse   = '0;
    bus.LeseInstruktion      = 1'b0;
    bus.DatenAdresse         = '0;
    bus.DatenRaus            = '0;
    bus.LeseDaten            = 1'b0;
    bus.SchreibeDaten        = 1'b0;
    bus.SpeicherLeseDaten    = '0;
    bus.SpeicherFertig       = 1'b0;

    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;

    // reset values
    check_strobes("rst", 1'b0, 1'b0);
    check_pulses("rst_pulses", 3'b000);
    check("rst_adr",    bus.SpeicherAdresse,      32'h0);
    check("rst_wdata",  bus.SpeicherSchreibDaten, 32'h0);
    check("rst_instr",  bus.Instruktion,          32'h0);
    check("rst_drein",  bus.DatenRein,            32'h0);
    check("rst_fehler", 32'(bus.Fehler),          32'h0);

    // SpeicherFertig with no access active is ignored
    bus.SpeicherFertig = 1'b1;
    tick();
    check_strobes("stray", 1'b0, 1'b0);
    check_pulses("stray_pulses", 3'b000);
    bus.SpeicherFertig = 1'b0;
    tick();
    check_pulses("stray_pulses2", 3'b000);

    // fetch at 0x10, memory done in the first strobe cycle
    bus.InstruktionAdresse = 32'h10;
    bus.LeseInstruktion    = 1'b1;
    tick();
    check_strobes("f1", 1'b1, 1'b0);
    check("f1_adr", bus.SpeicherAdresse, 32'h10);
    check_pulses("f1_early", 3'b000);
    bus.SpeicherLeseDaten = 32'hDEADBEEF;
    bus.SpeicherFertig    = 1'b1;
    tick();
    check_strobes("f2", 1'b0, 1'b0);
    check_pulses("f2_pulse", 3'b100);
    check("f2_instr", bus.Instruktion, 32'hDEADBEEF);
    bus.LeseInstruktion = 1'b0;
    bus.SpeicherFertig  = 1'b0;
    tick();
    check_pulses("f3_pulse_end", 3'b000);
    check_strobes("f3", 1'b0, 1'b0);

    // load and fetch together: load first, then fetch
    bus.DatenAdresse       = 32'h40;
    bus.InstruktionAdresse = 32'h44;
    bus.LeseDaten          = 1'b1;
    bus.LeseInstruktion    = 1'b1;
    tick();
    check_strobes("a1", 1'b1, 1'b0);
    check("a1_adr", bus.SpeicherAdresse, 32'h40);
    bus.SpeicherLeseDaten = 32'hAAAA0001;
    bus.SpeicherFertig    = 1'b1;
    tick();
    check_pulses("a2_pulse", 3'b010);
    check("a2_drein", bus.DatenRein,   32'hAAAA0001);
    check("a2_instr", bus.Instruktion, 32'hDEADBEEF);
    bus.LeseDaten      = 1'b0;
    bus.SpeicherFertig = 1'b0;
    tick();
    check_strobes("a3_idle", 1'b0, 1'b0);
    tick();
    check_strobes("a4", 1'b1, 1'b0);
    check("a4_adr", bus.SpeicherAdresse, 32'h44);
    bus.SpeicherLeseDaten = 32'hBBBB0002;
    bus.SpeicherFertig    = 1'b1;
    tick();
    check_pulses("a5_pulse", 3'b100);
    check("a5_instr", bus.Instruktion, 32'hBBBB0002);
    check("a5_drein", bus.DatenRein,   32'hAAAA0001);
    bus.LeseInstruktion = 1'b0;
    bus.SpeicherFertig  = 1'b0;
    tick();

    // both again after the fetch: load wins
    bus.DatenAdresse       = 32'h48;
    bus.InstruktionAdresse = 32'h4C;
    bus.LeseDaten          = 1'b1;
    bus.LeseInstruktion    = 1'b1;
    tick();
    check("b1_adr", bus.SpeicherAdresse, 32'h48);
    bus.SpeicherLeseDaten = 32'hCCCC0003;
    bus.SpeicherFertig    = 1'b1;
    tick();
    check_pulses("b2_pulse", 3'b010);
    check("b2_drein", bus.DatenRein, 32'hCCCC0003);
    bus.SpeicherFertig = 1'b0;
    tick();
    // both still high after a load: fetch wins
    tick();
    check("b4_adr", bus.SpeicherAdresse, 32'h4C);
    bus.SpeicherLeseDaten = 32'hDDDD0004;
    bus.SpeicherFertig    = 1'b1;
    tick();
    check_pulses("b5_pulse", 3'b100);
    check("b5_instr", bus.Instruktion, 32'hDDDD0004);
    bus.LeseDaten       = 1'b0;
    bus.LeseInstruktion = 1'b0;
    bus.SpeicherFertig  = 1'b0;
    tick();

    // store 0x12345678 to 0x20, done after 3 strobe cycles; request dropped after grant
    bus.DatenAdresse      = 32'h20;
    bus.DatenRaus         = 32'h12345678;
    bus.SchreibeDaten     = 1'b1;
    bus.SpeicherLeseDaten = 32'h99999999;
    tick();
    bus.SchreibeDaten = 1'b0;
    bus.DatenAdresse  = 32'hFFFF_FFF0;
    bus.DatenRaus     = 32'h0;
    for (int i = 0; i < 3; i++) begin
      check_strobes($sformatf("s%0d", i), 1'b0, 1'b1);
      check($sformatf("s%0d_adr", i),   bus.SpeicherAdresse,      32'h20);
      check($sformatf("s%0d_wdata", i), bus.SpeicherSchreibDaten, 32'h12345678);
      check_pulses($sformatf("s%0d_early", i), 3'b000);
      if (i == 2) bus.SpeicherFertig = 1'b1;
      tick();
    end
    check_strobes("s3", 1'b0, 1'b0);
    check_pulses("s3_pulse", 3'b001);
    check("s3_drein", bus.DatenRein, 32'hCCCC0003);
    bus.SpeicherFertig = 1'b0;
    tick();
    tick();
    check_strobes("s5_no_new", 1'b0, 1'b0);

    // reset in the 2nd strobe cycle of a load
    bus.DatenAdresse = 32'h60;
    bus.LeseDaten    = 1'b1;
    tick();
    check_strobes("r1", 1'b1, 1'b0);
    tick();
    check_strobes("r2", 1'b1, 1'b0);
    Reset = 1'b1;
    bus.SpeicherFertig = 1'b1;
    tick();
    Reset              = 1'b0;
    bus.LeseDaten      = 1'b0;
    bus.SpeicherFertig = 1'b0;
    check_strobes("r3", 1'b0, 1'b0);
    check_pulses("r3_pulses", 3'b000);
    check("r3_adr",   bus.SpeicherAdresse, 32'h0);
    check("r3_drein", bus.DatenRein,       32'h0);
    check("r3_instr", bus.Instruktion,     32'h0);
    tick();
    check_pulses("r4_pulses", 3'b000);
    bus.DatenAdresse = 32'h64;
    bus.LeseDaten    = 1'b1;
    tick();
    check("r5_adr", bus.SpeicherAdresse, 32'h64);
    bus.SpeicherLeseDaten = 32'h0BAD_F00D;
    bus.SpeicherFertig    = 1'b1;
    tick();
    check_pulses("r6_pulse", 3'b010);
    check("r6_drein", bus.DatenRein, 32'h0BADF00D);
    bus.LeseDaten      = 1'b0;
    bus.SpeicherFertig = 1'b0;
    tick();

    // store and load together: treated as a store
    bus.DatenAdresse  = 32'h70;
    bus.DatenRaus     = 32'h55AA55AA;
    bus.SchreibeDaten = 1'b1;
    bus.LeseDaten     = 1'b1;
    tick();
    check_strobes("w1", 1'b0, 1'b1);
    check("w1_wdata", bus.SpeicherSchreibDaten, 32'h55AA55AA);
    bus.SpeicherFertig = 1'b1;
    tick();
    check_pulses("w2_pulse", 3'b001);
    check("w2_drein", bus.DatenRein, 32'h0BADF00D);
    bus.SchreibeDaten  = 1'b0;
    bus.LeseDaten      = 1'b0;
    bus.SpeicherFertig = 1'b0;
    tick();
    check_strobes("w3", 1'b0, 1'b0);
    check("w3_fehler", 32'(bus.Fehler), 32'h0);

`ifdef ZEITLIMIT_EN
    // timeout after 4 strobe cycles without SpeicherFertig
    bus.DatenAdresse      = 32'h80;
    bus.LeseDaten         = 1'b1;
    bus.SpeicherLeseDaten = 32'h7777_7777;
    tick();
    bus.LeseDaten = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_strobes($sformatf("t%0d", i), 1'b1, 1'b0);
      tick();
    end
    check_strobes("t4", 1'b0, 1'b0);
    check_pulses("t4_pulse", 3'b010);
    check("t4_drein",  bus.DatenRein,      32'h0);
    check("t4_fehler", 32'(bus.Fehler),    32'h1);
    repeat (3) tick();
    check("t5_fehler", 32'(bus.Fehler),    32'h1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("t6_fehler", 32'(bus.Fehler),    32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
